// File: rtl/me_mem_loader_pkg.sv
// Shared types and default sizing for the motion-estimation memory loader.
package me_mem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_RB,
    ST_LOAD_SW,
    ST_CU_RST,
    ST_SEARCH,
    ST_DONE
  } state_t;

  localparam int DEF_DATA_WIDTH      = 8;
  localparam int DEF_RB_MEMORY_DEPTH = 256;
  localparam int DEF_SW_MEMORY_DEPTH = 961;
  localparam int DEF_SEARCH_CYCLES   = 4111;

  // Width needed to hold values 0..n-1, never less than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/me_mem_loader_if.sv
// Pixel stream, memory write ports and control-unit handshake of the loader.
// Optional macro ME_LOADER_RB_REUSE_EN adds the in_rb_reuse request line.
interface me_mem_loader_if
  import me_mem_loader_pkg::*;
#(
  parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int RB_MEMORY_DEPTH = DEF_RB_MEMORY_DEPTH,
  parameter int SW_MEMORY_DEPTH = DEF_SW_MEMORY_DEPTH
) ();

  localparam int RB_AW = idx_width(RB_MEMORY_DEPTH);
  localparam int SW_AW = idx_width(SW_MEMORY_DEPTH);

`ifdef ME_LOADER_RB_REUSE_EN
  logic                  in_rb_reuse;
`endif
  logic                  in_start;
  logic                  in_pix_valid;
  logic [DATA_WIDTH-1:0] in_pix_data;
  logic                  out_pix_ready;
  logic                  out_rb_wr_en;
  logic [RB_AW-1:0]      out_rb_wr_addr;
  logic [DATA_WIDTH-1:0] out_rb_wr_data;
  logic                  out_sw_wr_en;
  logic [SW_AW-1:0]      out_sw_wr_addr;
  logic [DATA_WIDTH-1:0] out_sw_wr_data;
  logic                  out_cu_rst;
  logic                  out_cu_ena;
  logic                  out_busy;
  logic                  out_done;

  modport master (
`ifdef ME_LOADER_RB_REUSE_EN
    output in_rb_reuse,
`endif
    output in_start, in_pix_valid, in_pix_data,
    input  out_pix_ready,
    input  out_rb_wr_en, out_rb_wr_addr, out_rb_wr_data,
    input  out_sw_wr_en, out_sw_wr_addr, out_sw_wr_data,
    input  out_cu_rst, out_cu_ena, out_busy, out_done
  );

  modport slave (
`ifdef ME_LOADER_RB_REUSE_EN
    input  in_rb_reuse,
`endif
    input  in_start, in_pix_valid, in_pix_data,
    output out_pix_ready,
    output out_rb_wr_en, out_rb_wr_addr, out_rb_wr_data,
    output out_sw_wr_en, out_sw_wr_addr, out_sw_wr_data,
    output out_cu_rst, out_cu_ena, out_busy, out_done
  );

endinterface

// File: rtl/me_load_addr_counter.sv
// Linear write-address counter that wraps at DEPTH and flags its last slot.
module me_load_addr_counter
  import me_mem_loader_pkg::*;
#(
  parameter int DEPTH = DEF_RB_MEMORY_DEPTH,
  parameter int AW    = idx_width(DEPTH)
) (
  input  logic          in_clk,
  input  logic          in_rst,
  input  logic          clr,
  input  logic          inc,
  output logic [AW-1:0] addr,
  output logic          last
);

  assign last = (addr == AW'(DEPTH - 1));

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst)
      addr <= '0;
    else if (clr)
      addr <= '0;
    else if (inc)
      addr <= last ? '0 : addr + AW'(1);
  end

endmodule

// File: rtl/me_mem_loader.sv
// Streams a reference block and a search window into their memories, then runs the control unit.
// Optional macro ME_LOADER_RB_REUSE_EN lets a start skip the reference-block load.
module me_mem_loader
  import me_mem_loader_pkg::*;
#(
  parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int RB_MEMORY_DEPTH = DEF_RB_MEMORY_DEPTH,
  parameter int SW_MEMORY_DEPTH = DEF_SW_MEMORY_DEPTH,
  parameter int SEARCH_CYCLES   = DEF_SEARCH_CYCLES
) (
  input  logic            in_clk,
  input  logic            in_rst,
  me_mem_loader_if.slave  bus
);

  localparam int RB_AW = idx_width(RB_MEMORY_DEPTH);
  localparam int SW_AW = idx_width(SW_MEMORY_DEPTH);
  localparam int SC_W  = idx_width(SEARCH_CYCLES);

  state_t                state, state_nxt;
  logic [RB_AW-1:0]      rb_addr;
  logic [SW_AW-1:0]      sw_addr;
  logic                  rb_last, sw_last;
  logic                  rb_xfer, sw_xfer;
  logic                  cnt_clr;
  logic                  rb_reuse;
  logic [SC_W-1:0]       search_cnt;
  logic                  rb_wr_en, sw_wr_en;
  logic [RB_AW-1:0]      rb_wr_addr;
  logic [SW_AW-1:0]      sw_wr_addr;
  logic [DATA_WIDTH-1:0] rb_wr_data, sw_wr_data;

`ifdef ME_LOADER_RB_REUSE_EN
  assign rb_reuse = bus.in_rb_reuse;
`else
  assign rb_reuse = 1'b0;
`endif

  assign rb_xfer = bus.in_pix_valid && (state == ST_LOAD_RB);
  assign sw_xfer = bus.in_pix_valid && (state == ST_LOAD_SW);
  // Both address counters restart from zero whenever the loader is parked.
  assign cnt_clr = (state == ST_IDLE);

  me_load_addr_counter #(.DEPTH(RB_MEMORY_DEPTH), .AW(RB_AW)) u_rb_cnt (
    .in_clk (in_clk),
    .in_rst (in_rst),
    .clr    (cnt_clr),
    .inc    (rb_xfer),
    .addr   (rb_addr),
    .last   (rb_last)
  );

  me_load_addr_counter #(.DEPTH(SW_MEMORY_DEPTH), .AW(SW_AW)) u_sw_cnt (
    .in_clk (in_clk),
    .in_rst (in_rst),
    .clr    (cnt_clr),
    .inc    (sw_xfer),
    .addr   (sw_addr),
    .last   (sw_last)
  );

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (bus.in_start) state_nxt = rb_reuse ? ST_LOAD_SW : ST_LOAD_RB;
      ST_LOAD_RB: if (rb_xfer && rb_last) state_nxt = ST_LOAD_SW;
      ST_LOAD_SW: if (sw_xfer && sw_last) state_nxt = ST_CU_RST;
      ST_CU_RST:  state_nxt = ST_SEARCH;
      ST_SEARCH:  if (search_cnt == '0) state_nxt = ST_DONE;
      ST_DONE:    state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Loaded with SEARCH_CYCLES-1 during CU_RST so SEARCH spans exactly SEARCH_CYCLES cycles.
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst)
      search_cnt <= '0;
    else if (state == ST_CU_RST)
      search_cnt <= SC_W'(SEARCH_CYCLES - 1);
    else if ((state == ST_SEARCH) && (search_cnt != '0))
      search_cnt <= search_cnt - SC_W'(1);
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      rb_wr_en   <= 1'b0;
      rb_wr_addr <= '0;
      rb_wr_data <= '0;
      sw_wr_en   <= 1'b0;
      sw_wr_addr <= '0;
      sw_wr_data <= '0;
    end else begin
      rb_wr_en <= rb_xfer;
      sw_wr_en <= sw_xfer;
      if (rb_xfer) begin
        rb_wr_addr <= rb_addr;
        rb_wr_data <= bus.in_pix_data;
      end
      if (sw_xfer) begin
        sw_wr_addr <= sw_addr;
        sw_wr_data <= bus.in_pix_data;
      end
    end
  end

  assign bus.out_pix_ready  = (state == ST_LOAD_RB) || (state == ST_LOAD_SW);
  assign bus.out_rb_wr_en   = rb_wr_en;
  assign bus.out_rb_wr_addr = rb_wr_addr;
  assign bus.out_rb_wr_data = rb_wr_data;
  assign bus.out_sw_wr_en   = sw_wr_en;
  assign bus.out_sw_wr_addr = sw_wr_addr;
  assign bus.out_sw_wr_data = sw_wr_data;
  assign bus.out_cu_rst     = (state == ST_CU_RST);
  assign bus.out_cu_ena     = (state == ST_SEARCH);
  assign bus.out_busy       = (state != ST_IDLE);
  assign bus.out_done       = (state == ST_DONE);

endmodule

// File: tb/tb_me_mem_loader.sv
// Bench for me_mem_loader: directed vector table plus randomized runs against a transaction-level model.
// Adds a reuse run when ME_LOADER_RB_REUSE_EN is defined.
module tb_me_mem_loader;
  import me_mem_loader_pkg::*;

  localparam int DW  = 8;
  localparam int RBD = 256;
  localparam int SWD = 961;
  localparam int SC  = 4111;
  localparam int ZERO_STALL = 1 + RBD + SWD + 1 + SC + 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  me_mem_loader_if #(.DATA_WIDTH(DW), .RB_MEMORY_DEPTH(RBD), .SW_MEMORY_DEPTH(SWD)) bus ();

  me_mem_loader #(
    .DATA_WIDTH(DW), .RB_MEMORY_DEPTH(RBD), .SW_MEMORY_DEPTH(SWD), .SEARCH_CYCLES(SC)
  ) dut (
    .in_clk (clk),
    .in_rst (rst),
    .bus    (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  // Model: 0 idle, 1 loading, 2 cu reset, 3 search, 4 done; n counts accepted pixels.
  int   m_mode, m_n, m_total, m_rb_cnt, m_left;
  logic p_rb_en, p_sw_en;
  int   p_rb_addr, p_sw_addr, p_rb_data, p_sw_data;
  int   cyc, t_start, t_done, done_seen;

  typedef struct {
    logic       start;
    logic       valid;
    logic [7:0] data;
    logic       ready;
    logic       busy;
    logic       rb_en;
    logic [7:0] rb_addr;
    logic [7:0] rb_data;
  } vec_t;
  vec_t tbl[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic chk_all_zero();
    chk("rst_pix_ready", bus.out_pix_ready, 0);
    chk("rst_busy", bus.out_busy, 0);
    chk("rst_cu_rst", bus.out_cu_rst, 0);
    chk("rst_cu_ena", bus.out_cu_ena, 0);
    chk("rst_done", bus.out_done, 0);
    chk("rst_rb_wr_en", bus.out_rb_wr_en, 0);
    chk("rst_rb_wr_addr", bus.out_rb_wr_addr, 0);
    chk("rst_rb_wr_data", bus.out_rb_wr_data, 0);
    chk("rst_sw_wr_en", bus.out_sw_wr_en, 0);
    chk("rst_sw_wr_addr", bus.out_sw_wr_addr, 0);
    chk("rst_sw_wr_data", bus.out_sw_wr_data, 0);
  endtask

  task automatic check_outputs();
    chk("pix_ready", bus.out_pix_ready, m_mode == 1);
    chk("busy", bus.out_busy, m_mode != 0);
    chk("cu_rst", bus.out_cu_rst, m_mode == 2);
    chk("cu_ena", bus.out_cu_ena, m_mode == 3);
    chk("done", bus.out_done, m_mode == 4);
    chk("rb_wr_en", bus.out_rb_wr_en, p_rb_en);
    if (p_rb_en) begin
      chk("rb_wr_addr", bus.out_rb_wr_addr, p_rb_addr);
      chk("rb_wr_data", bus.out_rb_wr_data, p_rb_data);
    end
    chk("sw_wr_en", bus.out_sw_wr_en, p_sw_en);
    if (p_sw_en) begin
      chk("sw_wr_addr", bus.out_sw_wr_addr, p_sw_addr);
      chk("sw_wr_data", bus.out_sw_wr_data, p_sw_data);
    end
    if (bus.out_done === 1'b1) begin
      done_seen++;
      t_done = cyc;
    end
  endtask

  task automatic model_step(input logic s, input logic v, input logic [7:0] d, input logic reuse);
    p_rb_en = 1'b0;
    p_sw_en = 1'b0;
    case (m_mode)
      0: if (s) begin
        m_mode   = 1;
        m_n      = 0;
        m_rb_cnt = reuse ? 0 : RBD;
        m_total  = m_rb_cnt + SWD;
        t_start  = cyc;
      end
      1: if (v) begin
        if (m_n < m_rb_cnt) begin
          p_rb_en = 1'b1; p_rb_addr = m_n; p_rb_data = d;
        end else begin
          p_sw_en = 1'b1; p_sw_addr = m_n - m_rb_cnt; p_sw_data = d;
        end
        m_n++;
        if (m_n == m_total) m_mode = 2;
      end
      2: begin m_mode = 3; m_left = SC; end
      3: begin m_left--; if (m_left == 0) m_mode = 4; end
      default: m_mode = 0;
    endcase
  endtask

  task automatic step(input logic s, input logic v, input logic [7:0] d, input logic reuse);
    bus.in_start     = s;
    bus.in_pix_valid = v;
    bus.in_pix_data  = d;
`ifdef ME_LOADER_RB_REUSE_EN
    bus.in_rb_reuse  = reuse;
`endif
    @(negedge clk);
    check_outputs();
    model_step(s, v, d, reuse);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run(input int vprob, input bit start_noise, input int rst_at,
                     input logic reuse, input bit count_chk);
    logic s, v;
    bit   was_reset;
    was_reset = 1'b0;
    done_seen = 0;
    t_done    = -1;
    step(1'b1, 1'($urandom % 2), 8'($urandom), reuse);
    for (int k = 0; k < 20000 && m_mode != 0 && !was_reset; k++) begin
      if (rst_at >= 0 && p_sw_en && p_sw_addr == rst_at) begin
        bus.in_start = 1'b0;
        bus.in_pix_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk_all_zero();
        m_mode = 0; p_rb_en = 1'b0; p_sw_en = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc++;
        was_reset = 1'b1;
      end else begin
        v = 1'(($urandom % 100) < vprob);
        s = start_noise && ((m_mode == 4) ||
            (((m_mode == 1 && m_n >= m_rb_cnt) || m_mode == 3) && ($urandom % 8 == 0)));
        step(s, v, 8'($urandom), reuse);
      end
    end
    if (m_mode != 0) begin
      checks++;
      errors++;
      $display("FAIL run_timeout: model mode %0d after cycle budget, expected 0", m_mode);
    end
    step(1'b0, 1'b1, 8'($urandom), reuse);
    step(1'b0, 1'b1, 8'($urandom), reuse);
    if (!was_reset) begin
      chk("done_pulses", done_seen, 1);
      if (count_chk) chk("start_to_done_cycles", t_done - t_start + 1, ZERO_STALL);
    end
  endtask

  initial begin
    tbl[0] = '{1'b0, 1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00};
    tbl[1] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00};
    tbl[2] = '{1'b1, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00};
    tbl[3] = '{1'b0, 1'b1, 8'h22, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00};
    tbl[4] = '{1'b0, 1'b0, 8'h5A, 1'b1, 1'b1, 1'b1, 8'h00, 8'h22};
    tbl[5] = '{1'b0, 1'b1, 8'h33, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00};
    tbl[6] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h01, 8'h33};
    tbl[7] = '{1'b1, 1'b1, 8'h44, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00};
    tbl[8] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h02, 8'h44};

    cyc = 0; m_mode = 0; m_n = 0; m_total = 0; m_rb_cnt = 0; m_left = 0;
    p_rb_en = 1'b0; p_sw_en = 1'b0; p_rb_addr = 0; p_sw_addr = 0; p_rb_data = 0; p_sw_data = 0;
    t_start = 0; t_done = -1; done_seen = 0;
    bus.in_start = 1'b0; bus.in_pix_valid = 1'b0; bus.in_pix_data = '0;
`ifdef ME_LOADER_RB_REUSE_EN
    bus.in_rb_reuse = 1'b0;
`endif
    rst = 1'b1;
    #12;
    chk_all_zero();
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      bus.in_start     = tbl[i].start;
      bus.in_pix_valid = tbl[i].valid;
      bus.in_pix_data  = tbl[i].data;
      @(negedge clk);
      chk($sformatf("vec%0d_ready", i), bus.out_pix_ready, tbl[i].ready);
      chk($sformatf("vec%0d_busy", i), bus.out_busy, tbl[i].busy);
      chk($sformatf("vec%0d_rb_wr_en", i), bus.out_rb_wr_en, tbl[i].rb_en);
      if (tbl[i].rb_en) begin
        chk($sformatf("vec%0d_rb_wr_addr", i), bus.out_rb_wr_addr, tbl[i].rb_addr);
        chk($sformatf("vec%0d_rb_wr_data", i), bus.out_rb_wr_data, tbl[i].rb_data);
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    bus.in_start = 1'b0;
    bus.in_pix_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;

    run(100, 1'b0, -1, 1'b0, 1'b1);
    run(60, 1'b0, -1, 1'b0, 1'b0);
    run(80, 1'b1, -1, 1'b0, 1'b0);
    run(70, 1'b0, 500, 1'b0, 1'b0);
    run(100, 1'b0, -1, 1'b0, 1'b1);
`ifdef ME_LOADER_RB_REUSE_EN
    run(100, 1'b0, -1, 1'b1, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
